// File: rtl/capture_trigger_ctrl.sv
// rtl/capture_trigger_ctrl.sv - write-side sample capture with pre/post counts and trigger marking
module capture_trigger_ctrl #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16,
    parameter int TMO_WIDTH = 20
) (
    input  logic                 WR_CLK,
    input  logic                 WR_RST_N,
    input  logic [WIDTH-1:0]     ADC_DATA,
    input  logic                 ADC_VALID,
    input  logic                 START,
    input  logic                 ABORT,
    input  logic                 FORCE,
    input  logic                 EDGE,
    input  logic [WIDTH-1:0]     LEVEL,
    input  logic [CNT_WIDTH-1:0] PRE_COUNT,
    input  logic [CNT_WIDTH-1:0] POST_COUNT,
    input  logic                 AUTO_EN,
    input  logic [TMO_WIDTH-1:0] AUTO_TIMEOUT,
    input  logic                 FIFO_FULL,
    output logic                 FIFO_WR,
    output logic [WIDTH:0]       FIFO_WR_DATA,
    output logic                 BUSY,
    output logic                 TRIGGERED,
    output logic                 DONE,
    output logic                 OVERFLOW
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRETRIG = 3'd1,
        S_ARMED   = 3'd2,
        S_POST    = 3'd3,
        S_FIN     = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic                 r_edge;
    logic [WIDTH-1:0]     r_level;
    logic [CNT_WIDTH-1:0] r_pre_count;
    logic [CNT_WIDTH-1:0] r_post_count;
    logic                 r_auto_en;
    logic [TMO_WIDTH-1:0] r_auto_tmo;

    logic [CNT_WIDTH-1:0] r_pre_cnt;
    logic [CNT_WIDTH-1:0] r_post_cnt;
    logic [TMO_WIDTH-1:0] r_tmo_cnt;
    logic [WIDTH-1:0]     r_prev;
    logic                 r_prev_valid;
    logic                 r_force_pend;
    logic                 r_triggered;
    logic                 r_overflow;
    logic                 r_fifo_wr;
    logic [WIDTH:0]       r_fifo_wr_data;

    logic                 w_busy;
    logic                 w_start;
    logic                 w_accept;
    logic                 w_edge_hit;
    logic                 w_auto_hit;
    logic                 w_trig;
    logic [CNT_WIDTH-1:0] w_pre_inc;
    logic [CNT_WIDTH-1:0] w_post_inc;

    assign w_busy     = (r_state == S_PRETRIG) || (r_state == S_ARMED) || (r_state == S_POST);
    assign w_start    = START && !ABORT && (r_state == S_IDLE);
    assign w_accept   = ADC_VALID && w_busy && !ABORT;
    assign w_pre_inc  = r_pre_cnt + CNT_WIDTH'(1);
    assign w_post_inc = r_post_cnt + CNT_WIDTH'(1);

    // Edge detection spans PRETRIG samples because r_prev tracks every accepted sample.
    assign w_edge_hit = r_prev_valid &&
                        (r_edge ? ((r_prev > r_level) && (ADC_DATA <= r_level))
                                : ((r_prev < r_level) && (ADC_DATA >= r_level)));
    assign w_auto_hit = r_auto_en && (r_tmo_cnt >= r_auto_tmo);
    assign w_trig     = w_accept && (r_state == S_ARMED) &&
                        (w_edge_hit || r_force_pend || w_auto_hit);

    always_comb begin
        w_state_nxt = r_state;
        if (ABORT) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (START)
                        w_state_nxt = (PRE_COUNT == '0) ? S_ARMED : S_PRETRIG;
                end
                S_PRETRIG: begin
                    if (w_accept && (w_pre_inc == r_pre_count))
                        w_state_nxt = S_ARMED;
                end
                S_ARMED: begin
                    if (w_trig)
                        w_state_nxt = (r_post_count == '0) ? S_FIN : S_POST;
                end
                S_POST: begin
                    if (w_accept && (w_post_inc == r_post_count))
                        w_state_nxt = S_FIN;
                end
                S_FIN:   w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge WR_CLK or negedge WR_RST_N) begin
        if (!WR_RST_N)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge WR_CLK or negedge WR_RST_N) begin
        if (!WR_RST_N) begin
            r_edge         <= 1'b0;
            r_level        <= '0;
            r_pre_count    <= '0;
            r_post_count   <= '0;
            r_auto_en      <= 1'b0;
            r_auto_tmo     <= '0;
            r_pre_cnt      <= '0;
            r_post_cnt     <= '0;
            r_tmo_cnt      <= '0;
            r_prev         <= '0;
            r_prev_valid   <= 1'b0;
            r_force_pend   <= 1'b0;
            r_triggered    <= 1'b0;
            r_overflow     <= 1'b0;
            r_fifo_wr      <= 1'b0;
            r_fifo_wr_data <= '0;
        end else begin
            if (w_start) begin
                r_edge       <= EDGE;
                r_level      <= LEVEL;
                r_pre_count  <= PRE_COUNT;
                r_post_count <= POST_COUNT;
                r_auto_en    <= AUTO_EN;
                r_auto_tmo   <= AUTO_TIMEOUT;
                r_pre_cnt    <= '0;
                r_post_cnt   <= '0;
            end else begin
                if (w_accept && (r_state == S_PRETRIG))
                    r_pre_cnt <= w_pre_inc;
                if (w_accept && (r_state == S_POST))
                    r_post_cnt <= w_post_inc;
            end

            // Held at zero outside ARMED so every entry starts the timeout fresh.
            if (r_state != S_ARMED)
                r_tmo_cnt <= '0;
            else if (r_tmo_cnt != '1)
                r_tmo_cnt <= r_tmo_cnt + TMO_WIDTH'(1);

            if (w_start) begin
                r_prev_valid <= 1'b0;
            end else if (w_accept) begin
                r_prev       <= ADC_DATA;
                r_prev_valid <= 1'b1;
            end

            if (ABORT || w_start || w_trig)
                r_force_pend <= 1'b0;
            else if (FORCE && (r_state == S_ARMED))
                r_force_pend <= 1'b1;

            if (ABORT || w_start)
                r_triggered <= 1'b0;
            else if (w_trig)
                r_triggered <= 1'b1;

            if (w_start)
                r_overflow <= 1'b0;
            else if (r_fifo_wr && FIFO_FULL)
                r_overflow <= 1'b1;

            r_fifo_wr <= w_accept;
            if (w_accept)
                r_fifo_wr_data <= {w_trig, ADC_DATA};
        end
    end

    assign FIFO_WR      = r_fifo_wr;
    assign FIFO_WR_DATA = r_fifo_wr_data;
    assign BUSY         = w_busy;
    assign TRIGGERED    = r_triggered;
    assign DONE         = (r_state == S_FIN);
    assign OVERFLOW     = r_overflow;

endmodule
